// File: rtl/rvi_addsub_pkg.sv
// Shared types for the RVI add/sub issue pipeline: command enum, op codes,
// the stage-1 payload and the command decoder.
package rvi_addsub_pkg;

    localparam int unsigned XLEN      = 64;
    // The payload tag width must match TAG_W of rvi_addsub_issue_pipe
    localparam int unsigned TAG_WIDTH = 5;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        ADDW = 3'd2,
        SUBW = 3'd3,
        SLT  = 3'd4,
        SLTU = 3'd5
    } cmd_e;

    // Op code bits: [0] add, [1] sub, [2] word
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ADDW = 3'b101;
    localparam logic [2:0] OP_SUBW = 3'b110;

    typedef struct packed {
        logic [2:0]           op;
        logic                 is_cmp;
        logic                 cmp_unsigned;
        logic [XLEN-1:0]      s1;
        logic [XLEN-1:0]      s2;
        logic [TAG_WIDTH-1:0] tag;
    } s1_payload_t;

    // Build the stage-1 payload; unknown command encodings behave as ADD
    function automatic s1_payload_t decode_cmd(input cmd_e cmd,
                                               input logic [XLEN-1:0] s1,
                                               input logic [XLEN-1:0] s2,
                                               input logic [TAG_WIDTH-1:0] tag);
        s1_payload_t p;
        p.op           = OP_ADD;
        p.is_cmp       = 1'b0;
        p.cmp_unsigned = 1'b0;
        p.s1           = s1;
        p.s2           = s2;
        p.tag          = tag;
        case (cmd)
            SUB:  p.op = OP_SUB;
            ADDW: p.op = OP_ADDW;
            SUBW: p.op = OP_SUBW;
            SLT: begin
                p.op     = OP_SUB;
                p.is_cmp = 1'b1;
            end
            SLTU: begin
                p.op           = OP_SUB;
                p.is_cmp       = 1'b1;
                p.cmp_unsigned = 1'b1;
            end
            default: p.op = OP_ADD;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rvi_addsub_core.sv
// Combinational add/sub/word-extend/less-than datapath.
module rvi_addsub_core
    import rvi_addsub_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    input  logic            is_cmp,
    input  logic            cmp_unsigned,
    output logic [XLEN-1:0] rslt
);

    logic [XLEN:0]   diff_ext;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] arith;
    logic            borrow;
    logic            lt;

    // Shared adder/subtractor; the 65-bit subtract's top bit is the unsigned borrow
    always_comb begin
        sum      = s1 + s2;
        diff_ext = {1'b0, s1} - {1'b0, s2};
        diff     = diff_ext[XLEN-1:0];
        borrow   = diff_ext[XLEN];
        arith    = op[1] ? diff : (op[0] ? sum : '0);
        lt       = cmp_unsigned ? borrow
                 : ((s1[XLEN-1] != s2[XLEN-1]) ? s1[XLEN-1] : diff[XLEN-1]);
        rslt     = arith;
        if (is_cmp) begin
            rslt = {{(XLEN-1){1'b0}}, lt};
        end else if (op[2]) begin
            rslt = {{(XLEN-32){arith[31]}}, arith[31:0]};
        end
    end

endmodule

// File: rtl/rvi_addsub_issue_pipe.sv
// Two-stage add/sub issue pipeline between the issue queue and writeback.
// S1 holds the decoded command, S2 holds the registered result.
// Optional build macro: RVI_ADDSUB_PERF_CNT_EN adds issue/stall counters.
module rvi_addsub_issue_pipe
    import rvi_addsub_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = 64,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  cmd_e                 in_cmd,
    input  logic [CPU_WIDTH-1:0] in_s1,
    input  logic [CPU_WIDTH-1:0] in_s2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [CPU_WIDTH-1:0] out_rslt,
    output logic [TAG_W-1:0]     out_tag,
`ifdef RVI_ADDSUB_PERF_CNT_EN
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt,
`endif
    output logic                 busy
);

    logic                 s1_vld_q;
    s1_payload_t          s1_q;
    logic                 s2_vld_q;
    logic [CPU_WIDTH-1:0] s2_rslt_q;
    logic [TAG_W-1:0]     s2_tag_q;
    logic [XLEN-1:0]      core_rslt;
    logic                 s2_adv;
    logic                 in_fire;

    // Handshake: S1 moves on when S2 is empty or draining this cycle
    always_comb begin
        s2_adv  = s1_vld_q && (!s2_vld_q || out_rdy);
        in_rdy  = !rst && (!s1_vld_q || s2_adv);
        in_fire = in_vld && in_rdy;
    end

    // Stage 1: capture decoded command and operands
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_vld_q <= 1'b1;
            s1_q     <= decode_cmd(in_cmd, in_s1, in_s2, TAG_WIDTH'(in_tag));
        end else if (s2_adv) begin
            s1_vld_q <= 1'b0;
        end
    end

    rvi_addsub_core u_core (
        .op           (s1_q.op),
        .s1           (s1_q.s1),
        .s2           (s1_q.s2),
        .is_cmp       (s1_q.is_cmp),
        .cmp_unsigned (s1_q.cmp_unsigned),
        .rslt         (core_rslt)
    );

    // Stage 2: register the result; hold it while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_rslt_q <= '0;
            s2_tag_q  <= '0;
        end else if (s2_adv) begin
            s2_vld_q  <= 1'b1;
            s2_rslt_q <= core_rslt;
            s2_tag_q  <= TAG_W'(s1_q.tag);
        end else if (out_rdy) begin
            s2_vld_q  <= 1'b0;
        end
    end

    // Outputs come straight from S2 state
    always_comb begin
        out_vld  = s2_vld_q;
        out_rslt = s2_rslt_q;
        out_tag  = s2_tag_q;
        busy     = s1_vld_q || s2_vld_q;
    end

`ifdef RVI_ADDSUB_PERF_CNT_EN
    // Free-running wrap-around counters for issue handshakes and output stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (in_fire) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (s2_vld_q && !out_rdy) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_rvi_addsub_issue_pipe.sv
// Self-checking bench for rvi_addsub_issue_pipe: directed cases plus a random
// stream scored against an arithmetic reference model and an in-order queue.
module tb_rvi_addsub_issue_pipe;
    import rvi_addsub_pkg::*;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] rslt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    cmd_e        in_cmd;
    logic [63:0] in_s1;
    logic [63:0] in_s2;
    logic [4:0]  in_tag;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_rslt;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef RVI_ADDSUB_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] m_issue;
    logic [31:0] m_stall;
`endif

    int   checks;
    int   errors;
    int   cyc;
    int   acc_cnt;
    int   out_cnt;
    int   first_out;
    int   last_out;
    exp_t exp_q[$];
    logic        prev_stall;
    logic [63:0] prev_rslt;
    logic [4:0]  prev_tag;

    rvi_addsub_issue_pipe #(
        .CPU_WIDTH (64),
        .TAG_W     (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_cmd   (in_cmd),
        .in_s1    (in_s1),
        .in_s2    (in_s2),
        .in_tag   (in_tag),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_rslt (out_rslt),
        .out_tag  (out_tag),
`ifdef RVI_ADDSUB_PERF_CNT_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain RISC-V arithmetic semantics
    function automatic logic [63:0] ref_model(input logic [2:0] c, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [63:0] w;
        case (c)
            3'd1: return a - b;
            3'd2: begin
                w = a + b;
                return {{32{w[31]}}, w[31:0]};
            end
            3'd3: begin
                w = a - b;
                return {{32{w[31]}}, w[31:0]};
            end
            3'd4: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd5: return (a < b) ? 64'd1 : 64'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 8));
            2: v = 64'h8000_0000_0000_0000 ^ 64'($urandom_range(0, 3));
            default: v = {32'hFFFF_FFFF, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive_rand(input logic [4:0] tag);
        in_cmd = cmd_e'(3'($urandom_range(0, 7)));
        in_s1  = rand64();
        in_s2  = ($urandom_range(0, 7) == 0) ? in_s1 : rand64();
        in_tag = tag;
    endtask

    // One clock: score handshakes just before the edge, then step past it
    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk("busy", {63'b0, busy}, {63'b0, exp_q.size() != 0});
        if (prev_stall) begin
            chk("stall_vld", {63'b0, out_vld}, 64'd1);
            chk("stall_rslt", out_rslt, prev_rslt);
            chk("stall_tag", {59'b0, out_tag}, {59'b0, prev_tag});
        end
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
`ifdef RVI_ADDSUB_PERF_CNT_EN
            m_issue = '0;
            m_stall = '0;
`endif
        end else begin
            if (in_vld && in_rdy) begin
                e.tag  = in_tag;
                e.rslt = ref_model(in_cmd, in_s1, in_s2);
                exp_q.push_back(e);
                acc_cnt++;
            end
            if (out_vld && out_rdy) begin
                chk("unexpected_out", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rslt", out_rslt, e.rslt);
                    chk("tag", {59'b0, out_tag}, {59'b0, e.tag});
                end
                if (out_cnt == 0) first_out = cyc;
                last_out = cyc;
                out_cnt++;
            end
`ifdef RVI_ADDSUB_PERF_CNT_EN
            if (in_vld && in_rdy) m_issue = m_issue + 32'd1;
            if (out_vld && !out_rdy) m_stall = m_stall + 32'd1;
`endif
            prev_stall = out_vld && !out_rdy;
            prev_rslt  = out_rslt;
            prev_tag   = out_tag;
        end
        @(posedge clk);
        #1;
        cyc++;
`ifdef RVI_ADDSUB_PERF_CNT_EN
        chk("perf_issue", {32'b0, perf_issue_cnt}, {32'b0, m_issue});
        chk("perf_stall", {32'b0, perf_stall_cnt}, {32'b0, m_stall});
`endif
    endtask

    // Single command through an idle pipe; checks edge count to out_vld
    task automatic run_one(input string name, input cmd_e c, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] t,
                           input logic [63:0] exp);
        int n;
        in_vld = 1'b1;
        in_cmd = c;
        in_s1  = a;
        in_s2  = b;
        in_tag = t;
        chk({name, "_in_rdy"}, {63'b0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        n = 1;
        while (!out_vld && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd2);
        chk({name, "_rslt"}, out_rslt, exp);
        chk({name, "_tag"}, {59'b0, out_tag}, {59'b0, t});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   a0;
        int   o0;
        int   n;
        logic [63:0] s1v [3];
        logic [63:0] s2v [3];
        cmd_e        cv  [3];

        checks = 0; errors = 0; cyc = 0; acc_cnt = 0; out_cnt = 0;
        first_out = 0; last_out = 0; prev_stall = 1'b0;
        prev_rslt = '0; prev_tag = '0;
`ifdef RVI_ADDSUB_PERF_CNT_EN
        m_issue = '0; m_stall = '0;
`endif
        rst = 1'b1; in_vld = 1'b0; in_cmd = ADD; in_s1 = '0; in_s2 = '0; in_tag = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", {63'b0, in_rdy}, 64'd0);
        chk("rst_out_vld", {63'b0, out_vld}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_out_rslt", out_rslt, 64'd0);
        chk("rst_out_tag", {59'b0, out_tag}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_rdy", {63'b0, in_rdy}, 64'd1);

        run_one("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd0);
        run_one("addw_ovf", ADDW, 64'h7FFF_FFFF, 64'd1, 5'd4, 64'hFFFF_FFFF_8000_0000);
        run_one("subw_neg", SUBW, 64'd0, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("slt_neg", SLT, 64'h8000_0000_0000_0000, 64'd1, 5'd6, 64'd1);
        run_one("sltu_big", SLTU, 64'h8000_0000_0000_0000, 64'd1, 5'd7, 64'd0);
        run_one("slt_eq", SLT, 64'd5, 64'd5, 5'd8, 64'd0);
        run_one("sub_basic", SUB, 64'd3, 64'd10, 5'd9, 64'hFFFF_FFFF_FFFF_FFF9);

        // Back-to-back stream with the consumer always ready
        out_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            in_vld = 1'b1;
            drive_rand(5'(k + 10));
            chk("b2b_in_rdy", {63'b0, in_rdy}, 64'd1);
            tick();
        end
        in_vld = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_count", 64'(out_cnt), 64'd8);
        chk("b2b_consecutive", 64'(last_out - first_out), 64'd7);

        // Consumer stalls for 4 cycles with 3 commands offered
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cv[k]  = cmd_e'(3'($urandom_range(0, 5)));
            s1v[k] = rand64();
            s2v[k] = rand64();
        end
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1;
            in_cmd = cv[acc_cnt - a0];
            in_s1  = s1v[acc_cnt - a0];
            in_s2  = s2v[acc_cnt - a0];
            in_tag = 5'(20 + acc_cnt - a0);
            tick();
        end
        chk("stall_accepted", 64'(acc_cnt - a0), 64'd2);
        chk("stall_in_rdy", {63'b0, in_rdy}, 64'd0);
        out_rdy = 1'b1;
        n = 0;
        while ((acc_cnt - a0 < 3 || exp_q.size() != 0) && n < 20) begin
            in_vld = (acc_cnt - a0) < 3;
            if (acc_cnt - a0 < 3) begin
                in_cmd = cv[acc_cnt - a0];
                in_s1  = s1v[acc_cnt - a0];
                in_s2  = s2v[acc_cnt - a0];
                in_tag = 5'(20 + acc_cnt - a0);
            end
            tick();
            n++;
        end
        in_vld = 1'b0;
        chk("stall_drained", 64'(out_cnt - o0), 64'd3);

        // Reset with both stages full
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld = 1'b1;
            drive_rand(5'(k + 25));
            tick();
        end
        chk("full_busy", {63'b0, busy}, 64'd1);
        chk("full_out_vld", {63'b0, out_vld}, 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_vld", {63'b0, out_vld}, 64'd0);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_out_rslt", out_rslt, 64'd0);
        chk("mid_rst_in_rdy", {63'b0, in_rdy}, 64'd0);
`ifdef RVI_ADDSUB_PERF_CNT_EN
        chk("mid_rst_perf_issue", {32'b0, perf_issue_cnt}, 64'd0);
        chk("mid_rst_perf_stall", {32'b0, perf_stall_cnt}, 64'd0);
`endif
        rst = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        tick();

        // Random traffic on both handshakes
        for (int k = 0; k < 400; k++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 9) < 7);
            drive_rand(5'($urandom));
            tick();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("final_drain", 64'(exp_q.size()), 64'd0);
        chk("final_idle", {63'b0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
